// File: rtl/spm_dac_pkg.sv
// Shared constants, FSM state type and stream-to-DAC code conversion for the SPM DAC writer.
package spm_dac_pkg;

    localparam int unsigned DAC_BITS   = 20;
    localparam int unsigned FRAME_BITS = 24;
    localparam int unsigned LANES      = 4;
    localparam logic [3:0]  CMD_WR_DAC = 4'b0001;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_CAPTURE,
        ST_SHIFT,
        ST_GAP,
        ST_LDAC
    } state_t;

    typedef logic [LANES-1:0][FRAME_BITS-1:0] frame4_t;
    typedef logic [LANES-1:0][DAC_BITS-1:0]   code4_t;

    // Top 20 bits rounded half up on bit 11; only the positive full-scale code can overflow.
    function automatic logic [DAC_BITS-1:0] to_dac_code(input logic [31:0] d);
        if (d[31:12] == 20'h7FFFF && d[11]) begin
            return 20'h7FFFF;
        end
        return d[31:12] + DAC_BITS'(d[11]);
    endfunction

endpackage

// File: rtl/axis_spm_dac_writer_if.sv
// Four parallel AXI-Stream lanes (X, Y, Z, U) feeding the DAC writer.
interface axis_spm_dac_writer_if #(
    parameter int unsigned TDATA_W = 32
);
    logic [3:0][TDATA_W-1:0] tdata;
    logic [3:0]              tvalid;
    logic [3:0]              tready;

    modport master (output tdata, output tvalid, input  tready);
    modport slave  (input  tdata, input  tvalid, output tready);
endinterface

// File: rtl/spm_spi_shift4.sv
// Four-lane parallel 24-bit SPI serializer, shared SCLK/SYNC_n, MSB first.
module spm_spi_shift4
    import spm_dac_pkg::*;
#(
    parameter int unsigned CLKDIV = 4
) (
    input  logic             a_clk,
    input  logic             a_rst,
    input  logic             start,
    input  frame4_t          frame,
    output logic             last_c,
    output logic             sclk,
    output logic             sync_n,
    output logic [LANES-1:0] sdi
);

    localparam int unsigned DIV_W = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam int unsigned BIT_W = $clog2(FRAME_BITS);

    logic [DIV_W-1:0] div_cnt;
    logic [BIT_W-1:0] bit_cnt;
    frame4_t          sr;
    logic             div_end_c;

    assign div_end_c = (div_cnt == DIV_W'(CLKDIV - 1));
    // High on the final cycle of the last bit's low phase; the frame ends at this edge.
    assign last_c    = !sync_n && div_end_c && !sclk && (bit_cnt == '0);

    // Each bit: sclk high CLKDIV cycles, then low CLKDIV cycles; next bit presented as sclk rises.
    always_ff @(posedge a_clk) begin
        if (a_rst) begin
            sclk    <= 1'b1;
            sync_n  <= 1'b1;
            sdi     <= '0;
            div_cnt <= '0;
            bit_cnt <= '0;
            sr      <= '0;
        end else if (sync_n) begin
            if (start) begin
                sync_n  <= 1'b0;
                sclk    <= 1'b1;
                div_cnt <= '0;
                bit_cnt <= BIT_W'(FRAME_BITS - 1);
                for (int unsigned i = 0; i < LANES; i++) begin
                    sdi[i] <= frame[i][FRAME_BITS-1];
                    sr[i]  <= frame[i] << 1;
                end
            end
        end else if (!div_end_c) begin
            div_cnt <= div_cnt + 1'b1;
        end else begin
            div_cnt <= '0;
            if (sclk) begin
                sclk <= 1'b0;
            end else if (bit_cnt == '0) begin
                sync_n <= 1'b1;
                sclk   <= 1'b1;
                sdi    <= '0;
            end else begin
                sclk    <= 1'b1;
                bit_cnt <= bit_cnt - 1'b1;
                for (int unsigned i = 0; i < LANES; i++) begin
                    sdi[i] <= sr[i][FRAME_BITS-1];
                    sr[i]  <= sr[i] << 1;
                end
            end
        end
    end

endmodule

// File: rtl/axis_spm_dac_writer.sv
// SPM X/Y/Z/U stream sink: capture, convert to 20-bit codes, shift to four DACs, pulse LDAC_n.
module axis_spm_dac_writer
    import spm_dac_pkg::*;
#(
    parameter int unsigned SAXIS_TDATA_WIDTH = 32,
    parameter int unsigned CLKDIV            = 4,
    parameter int unsigned SYNC_GAP          = 4,
    parameter int unsigned LDAC_W            = 2,
    parameter logic [23:0] INIT_WORD         = 24'h200012
) (
    input  logic                  a_clk,
    input  logic                  a_rst,
    input  logic                  enable,
    axis_spm_dac_writer_if.slave  s_axis,
    output logic                  dac_sclk,
    output logic                  dac_sync_n,
    output logic [LANES-1:0]      dac_sdi,
    output logic                  dac_ldac_n,
    output logic                  busy,
    output logic [31:0]           frame_count
);

    localparam int unsigned CNT_MAX = (SYNC_GAP > LDAC_W) ? SYNC_GAP : LDAC_W;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    state_t           state;
    code4_t           held;
    code4_t           code_next_c;
    frame4_t          frame_c;
    logic             start_c;
    logic             last_c;
    logic             init_frame;
    logic [CNT_W-1:0] cnt;

    // Lanes without tvalid fall back to their held code; INIT sends the control word everywhere.
    always_comb begin
        code_next_c = held;
        frame_c     = '0;
        start_c     = (state == ST_INIT) || (state == ST_CAPTURE);
        for (int unsigned i = 0; i < LANES; i++) begin
            if (s_axis.tvalid[i]) begin
                code_next_c[i] = to_dac_code(s_axis.tdata[i][SAXIS_TDATA_WIDTH-1 -: 32]);
            end
            frame_c[i] = (state == ST_INIT) ? INIT_WORD : {CMD_WR_DAC, code_next_c[i]};
        end
    end

    spm_spi_shift4 #(
        .CLKDIV (CLKDIV)
    ) u_shift (
        .a_clk  (a_clk),
        .a_rst  (a_rst),
        .start  (start_c),
        .frame  (frame_c),
        .last_c (last_c),
        .sclk   (dac_sclk),
        .sync_n (dac_sync_n),
        .sdi    (dac_sdi)
    );

    // Frame sequencer: capture, shift, SYNC gap, LDAC pulse and completed-frame counter.
    always_ff @(posedge a_clk) begin
        if (a_rst) begin
            state         <= ST_INIT;
            busy          <= 1'b1;
            s_axis.tready <= '0;
            dac_ldac_n    <= 1'b1;
            frame_count   <= '0;
            held          <= '0;
            init_frame    <= 1'b1;
            cnt           <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    state <= ST_SHIFT;
                end
                ST_IDLE: begin
                    if (enable) begin
                        state         <= ST_CAPTURE;
                        busy          <= 1'b1;
                        s_axis.tready <= '1;
                    end
                end
                ST_CAPTURE: begin
                    s_axis.tready <= '0;
                    held          <= code_next_c;
                    init_frame    <= 1'b0;
                    state         <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (last_c) begin
                        state <= ST_GAP;
                        cnt   <= '0;
                    end
                end
                ST_GAP: begin
                    if (cnt == CNT_W'(SYNC_GAP - 1)) begin
                        cnt <= '0;
                        if (init_frame) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state      <= ST_LDAC;
                            dac_ldac_n <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_LDAC: begin
                    if (cnt == CNT_W'(LDAC_W - 1)) begin
                        cnt         <= '0;
                        dac_ldac_n  <= 1'b1;
                        frame_count <= frame_count + 32'd1;
                        state       <= ST_IDLE;
                        busy        <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_spm_dac_writer.sv
// Directed bench for axis_spm_dac_writer: decodes SPI frames per lane and checks timing/codes.
module tb_axis_spm_dac_writer;

    localparam int CLKDIV   = 4;
    localparam int SYNC_GAP = 4;
    localparam int LDAC_W   = 2;
    localparam int PERIOD   = 1 + 48 * CLKDIV + SYNC_GAP + LDAC_W + 1;
    localparam int BUDGET   = 2000;

    logic        a_clk  = 1'b0;
    logic        a_rst  = 1'b1;
    logic        enable = 1'b0;
    logic        dac_sclk;
    logic        dac_sync_n;
    logic [3:0]  dac_sdi;
    logic        dac_ldac_n;
    logic        busy;
    logic [31:0] frame_count;

    axis_spm_dac_writer_if #(.TDATA_W(32)) s_axis ();

    axis_spm_dac_writer #(
        .SAXIS_TDATA_WIDTH (32),
        .CLKDIV            (CLKDIV),
        .SYNC_GAP          (SYNC_GAP),
        .LDAC_W            (LDAC_W),
        .INIT_WORD         (24'h200012)
    ) dut (
        .a_clk       (a_clk),
        .a_rst       (a_rst),
        .enable      (enable),
        .s_axis      (s_axis),
        .dac_sclk    (dac_sclk),
        .dac_sync_n  (dac_sync_n),
        .dac_sdi     (dac_sdi),
        .dac_ldac_n  (dac_ldac_n),
        .busy        (busy),
        .frame_count (frame_count)
    );

    always #5 a_clk = ~a_clk;

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Line monitor: shifts sdi in on each sclk falling edge inside a SYNC_n frame.
    typedef struct {
        logic [3:0][23:0] w;
        int               bits;
    } frame_rec_t;

    frame_rec_t       frames_q[$];
    int               start_q[$];
    int               cyc = 0;
    logic [3:0][23:0] cur_w = '0;
    int               cur_bits = 0;
    logic             prev_sclk = 1'b1;
    logic             prev_sync = 1'b1;
    logic             prev_ldac = 1'b1;
    int               ldac_pulses = 0;
    int               ldac_cycles = 0;
    int               tready_cycles = 0;

    always @(posedge a_clk) cyc <= cyc + 1;

    always @(negedge a_clk) begin
        if (prev_sync && !dac_sync_n) begin
            start_q.push_back(cyc);
            cur_bits = 0;
            cur_w    = '0;
        end
        if (!dac_sync_n && prev_sclk && !dac_sclk) begin
            for (int i = 0; i < 4; i++) cur_w[i] = {cur_w[i][22:0], dac_sdi[i]};
            cur_bits++;
        end
        if (!prev_sync && dac_sync_n) frames_q.push_back('{w: cur_w, bits: cur_bits});
        if (!dac_ldac_n) ldac_cycles++;
        if (prev_ldac && !dac_ldac_n) ldac_pulses++;
        if (s_axis.tready == 4'hF) tready_cycles++;
        prev_sclk = dac_sclk;
        prev_sync = dac_sync_n;
        prev_ldac = dac_ldac_n;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge a_clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < BUDGET) begin tick(1); n++; end
        check(tag, 32'(busy), 32'd0);
    endtask

    task automatic wait_count(input int target, input string tag);
        int n = 0;
        while (frame_count !== 32'(target) && n < BUDGET) begin tick(1); n++; end
        check(tag, frame_count, 32'(target));
    endtask

    task automatic wait_tready(input string tag);
        int n = 0;
        while (s_axis.tready !== 4'hF && n < BUDGET) begin tick(1); n++; end
        check(tag, 32'(s_axis.tready), 32'hF);
    endtask

    task automatic wait_bits(input int target, input string tag);
        int n = 0;
        int s0 = start_q.size();
        while (!(start_q.size() > s0 && cur_bits >= target) && n < BUDGET) begin tick(1); n++; end
        check(tag, 32'(cur_bits), 32'(target));
    endtask

    task automatic check_frame(input string tag, input logic [23:0] e0, input logic [23:0] e1,
                               input logic [23:0] e2, input logic [23:0] e3);
        frame_rec_t f;
        if (frames_q.size() > 0) f = frames_q[$];
        else begin f.w = '0; f.bits = 0; end
        check({tag, "_bits"}, 32'(f.bits), 32'd24);
        check({tag, "_lane1"}, 32'(f.w[0]), 32'(e0));
        check({tag, "_lane2"}, 32'(f.w[1]), 32'(e1));
        check({tag, "_lane3"}, 32'(f.w[2]), 32'(e2));
        check({tag, "_lane4"}, 32'(f.w[3]), 32'(e3));
    endtask

    initial begin
        int cap_cyc;
        s_axis.tdata  = '0;
        s_axis.tvalid = '0;
        tick(3);

        // Reset values
        check("rst_sclk", 32'(dac_sclk), 32'd1);
        check("rst_sync_n", 32'(dac_sync_n), 32'd1);
        check("rst_sdi", 32'(dac_sdi), 32'd0);
        check("rst_ldac_n", 32'(dac_ldac_n), 32'd1);
        check("rst_tready", 32'(s_axis.tready), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_count", frame_count, 32'd0);

        // INIT frame after reset release
        a_rst = 1'b0;
        wait_idle("init_idle");
        check("init_nframes", 32'(frames_q.size()), 32'd1);
        check_frame("init", 24'h200012, 24'h200012, 24'h200012, 24'h200012);
        check("init_no_ldac", 32'(ldac_pulses), 32'd0);
        check("init_count", frame_count, 32'd0);

        // Two back-to-back data frames with enable held
        s_axis.tdata[0] = 32'h12345800;
        s_axis.tdata[1] = 32'h7FFFFFFF;
        s_axis.tdata[2] = 32'h80000000;
        s_axis.tdata[3] = 32'hFFFFF7FF;
        s_axis.tvalid   = 4'hF;
        enable = 1'b1;
        wait_tready("cap1_tready");
        cap_cyc = cyc;
        tick(1);
        s_axis.tdata[0]  = 32'h00000800;
        s_axis.tdata[2]  = 32'h12345678;
        s_axis.tvalid[2] = 1'b0;
        wait_count(1, "f1_count");
        check_frame("f1", 24'h112346, 24'h17FFFF, 24'h180000, 24'h1FFFFF);
        check("f1_sync_after_cap", 32'(start_q[1] - cap_cyc), 32'd1);
        check("f1_ldac_pulses", 32'(ldac_pulses), 32'd1);
        check("f1_ldac_width", 32'(ldac_cycles), 32'(LDAC_W));
        wait_count(2, "f2_count");
        enable = 1'b0;
        check_frame("f2", 24'h100001, 24'h17FFFF, 24'h180000, 24'h1FFFFF);
        check("f2_period", 32'(start_q[2] - start_q[1]), 32'(PERIOD));
        check("f2_tready_cycles", 32'(tready_cycles), 32'd2);
        check("f2_ldac_cycles", 32'(ldac_cycles), 32'(2 * LDAC_W));
        tick(50);
        check("f2_idle_busy", 32'(busy), 32'd0);
        check("f2_no_restart", 32'(start_q.size()), 32'd3);

        // enable dropped mid-frame: frame completes with one LDAC, then idle
        enable = 1'b1;
        wait_bits(10, "f3_bit10");
        enable = 1'b0;
        wait_idle("f3_idle");
        check("f3_count", frame_count, 32'd3);
        check("f3_ldac_pulses", 32'(ldac_pulses), 32'd3);
        check_frame("f3", 24'h100001, 24'h17FFFF, 24'h180000, 24'h1FFFFF);
        tick(PERIOD);
        check("f3_no_restart", 32'(start_q.size()), 32'd4);

        // Reset mid-frame: outputs reset next cycle, INIT frame replays
        enable = 1'b1;
        wait_bits(12, "f4_bit12");
        a_rst = 1'b1;
        tick(1);
        check("mrst_sync_n", 32'(dac_sync_n), 32'd1);
        check("mrst_sclk", 32'(dac_sclk), 32'd1);
        check("mrst_sdi", 32'(dac_sdi), 32'd0);
        check("mrst_ldac_n", 32'(dac_ldac_n), 32'd1);
        check("mrst_count", frame_count, 32'd0);
        check("mrst_busy", 32'(busy), 32'd1);
        a_rst = 1'b0;
        enable = 1'b0;
        s_axis.tvalid = 4'h0;
        wait_idle("reinit_idle");
        check_frame("reinit", 24'h200012, 24'h200012, 24'h200012, 24'h200012);
        check("reinit_count", frame_count, 32'd0);

        // No tvalid after reset: frame runs from cleared held codes
        enable = 1'b1;
        wait_count(1, "held0_count");
        enable = 1'b0;
        check_frame("held0", 24'h100000, 24'h100000, 24'h100000, 24'h100000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
